// File: rtl/pin_edge_conditioner.sv
// rtl/pin_edge_conditioner.sv - synchronise, deglitch and time an asynchronous input pin
//
// Conditions a raw external pin for use in the clk domain: a synchroniser
// chain, a consecutive-sample glitch filter, one-cycle rise/fall strobes, a
// rising-edge period counter and a loss-of-signal flag.
//
// Ports:
//   clk          system clock, all logic in this domain
//   rst          synchronous active-high reset
//   pin_in       raw asynchronous pin
//   level        filtered, synchronised pin level
//   rise_pulse   one-cycle strobe on each accepted 0->1 transition
//   fall_pulse   one-cycle strobe on each accepted 1->0 transition
//   period       clk cycles between the last two rising edges
//   period_valid one-cycle strobe when period is updated
//   signal_lost  high when no rising edge arrived within TIMEOUT cycles
//   edge_count   count of accepted rising edges, wraps at 2^16

module pin_edge_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int PERIOD_W    = 32,
  parameter int TIMEOUT     = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pin_in,
  output logic                level,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                signal_lost,
  output logic [15:0]         edge_count
);

  localparam int                   FCNT_W      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0]    FCNT_LAST   = FCNT_W'(FILTER_LEN - 1);
  localparam logic [PERIOD_W-1:0]  PCNT_MAX    = '1;
  localparam logic [PERIOD_W-1:0]  TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FCNT_W-1:0]      fcnt;
  logic [PERIOD_W-1:0]    pcnt;
  logic                   armed;

  logic                   accept;
  logic                   rise_acc;
  logic                   fall_acc;
  logic                   timeout_hit;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept      = 1'b0;
    rise_acc    = 1'b0;
    fall_acc    = 1'b0;
    timeout_hit = 1'b0;
    // A level change is accepted on the FILTER_LEN-th consecutive disagreeing sample.
    accept      = (s != level) && (fcnt == FCNT_LAST);
    rise_acc    = accept && s;
    fall_acc    = accept && !s;
    // A rise in the timeout cycle wins, so the timeout is suppressed then.
    timeout_hit = armed && (pcnt == TIMEOUT_CNT) && !rise_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      level        <= 1'b0;
      fcnt         <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      pcnt         <= '0;
      armed        <= 1'b0;
      signal_lost  <= 1'b1;
      edge_count   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};

      if (s == level) begin
        fcnt <= '0;
      end else if (accept) begin
        level <= s;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end

      // Registered alongside level so the strobe lands in level's first new cycle.
      rise_pulse   <= rise_acc;
      fall_pulse   <= fall_acc;
      period_valid <= rise_acc && armed;

      if (rise_acc) begin
        // The first rise after reset or loss only arms; no previous edge to measure from.
        if (armed) begin
          period <= pcnt;
        end
        pcnt        <= PERIOD_W'(1);
        armed       <= 1'b1;
        signal_lost <= 1'b0;
        edge_count  <= edge_count + 16'd1;
      end else begin
        if (pcnt != PCNT_MAX) begin
          pcnt <= pcnt + PERIOD_W'(1);
        end
        if (timeout_hit) begin
          signal_lost <= 1'b1;
          armed       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pin_edge_conditioner.sv
// tb/tb_pin_edge_conditioner.sv - directed self-checking bench for pin_edge_conditioner

module tb_pin_edge_conditioner;

  logic        clk;
  logic        rst;
  logic        pin_in;
  logic        level;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [31:0] period;
  logic        period_valid;
  logic        signal_lost;
  logic [15:0] edge_count;

  logic        pin2;
  logic        level2;
  logic        rise2;
  logic        fall2;
  logic [31:0] period2;
  logic        pv2;
  logic        lost2;
  logic [15:0] edge_count2;

  int checks;
  int errors;

  int rise_cnt;
  int fall_cnt;
  int both_cnt;
  int pv_orphan;
  logic        last_pv;
  logic        last_lost;
  logic [31:0] last_period;

  pin_edge_conditioner #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .PERIOD_W(32), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .level(level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .signal_lost(signal_lost), .edge_count(edge_count)
  );

  // Unfiltered instance: one rise every two cycles makes the 16-bit wrap reachable.
  pin_edge_conditioner #(
    .SYNC_STAGES(2), .FILTER_LEN(1), .PERIOD_W(32), .TIMEOUT(100)
  ) dut_wrap (
    .clk(clk), .rst(rst), .pin_in(pin2), .level(level2),
    .rise_pulse(rise2), .fall_pulse(fall2), .period(period2),
    .period_valid(pv2), .signal_lost(lost2), .edge_count(edge_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rise_cnt    = 0;
    fall_cnt    = 0;
    both_cnt    = 0;
    pv_orphan   = 0;
    last_pv     = 1'b0;
    last_lost   = 1'b0;
    last_period = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rise_pulse) begin
        rise_cnt    = rise_cnt + 1;
        last_pv     = period_valid;
        last_lost   = signal_lost;
        last_period = period;
      end
      if (fall_pulse) fall_cnt = fall_cnt + 1;
      if (rise_pulse && fall_pulse) both_cnt = both_cnt + 1;
      if (period_valid && !rise_pulse) pv_orphan = pv_orphan + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input int n);
    pin_in = v;
    repeat (n) tick();
  endtask

  int r0;
  int n;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pin_in = 1'b0;
    pin2   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check_eq("rst_level", level, 0);
    check_eq("rst_rise", rise_pulse, 0);
    check_eq("rst_fall", fall_pulse, 0);
    check_eq("rst_period", period, 0);
    check_eq("rst_pv", period_valid, 0);
    check_eq("rst_edge_count", edge_count, 0);
    check_eq("rst_lost", signal_lost, 1);

    // Clean step: rise lands on the sixth edge after the first sampling edge.
    pin_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq($sformatf("lat_rise_%0d", k), rise_pulse, (k == 6));
      if (k == 5) check_eq("lat_level_before", level, 0);
      if (k == 6) begin
        check_eq("lat_level", level, 1);
        check_eq("lat_edge_count", edge_count, 1);
        check_eq("lat_lost", signal_lost, 0);
        check_eq("lat_pv", period_valid, 0);
      end
    end
    drive(1'b0, 10);
    check_eq("fall_once", fall_cnt, 1);
    check_eq("rise_once", rise_cnt, 1);

    // Glitches of 1..3 cycles never reach level.
    for (int g = 1; g <= 3; g++) begin
      drive(1'b1, g);
      check_eq($sformatf("glitch%0d_level_hi", g), level, 0);
      drive(1'b0, 10);
      check_eq($sformatf("glitch%0d_level", g), level, 0);
      check_eq($sformatf("glitch%0d_rise", g), rise_cnt, 1);
    end
    drive(1'b1, 4);
    drive(1'b0, 12);
    check_eq("pulse4_rise", rise_cnt, 2);
    check_eq("pulse4_fall", fall_cnt, 2);

    // 20-cycle square wave, 10 high.
    for (int p = 0; p < 6; p++) begin
      r0 = rise_cnt;
      drive(1'b1, 10);
      check_eq($sformatf("sq%0d_rise", p), rise_cnt - r0, 1);
      check_eq($sformatf("sq%0d_edge_count", p), edge_count, 3 + p);
      if (p > 0) begin
        check_eq($sformatf("sq%0d_pv", p), last_pv, 1);
        check_eq($sformatf("sq%0d_period", p), last_period, 20);
      end
      drive(1'b0, 10);
    end

    // Stop the wave after a rise and let it time out.
    r0 = rise_cnt;
    pin_in = 1'b1;
    n = 0;
    while (rise_cnt == r0 && n < 20) begin
      tick();
      n = n + 1;
    end
    check_eq("stop_rise_latency", n, 6);
    repeat (99) tick();
    check_eq("lost_not_yet", signal_lost, 0);
    tick();
    check_eq("lost_set", signal_lost, 1);
    drive(1'b0, 10);
    r0 = rise_cnt;
    drive(1'b1, 10);
    check_eq("rearm_rise", rise_cnt - r0, 1);
    check_eq("rearm_lost", last_lost, 0);
    check_eq("rearm_pv", last_pv, 0);
    check_eq("rearm_lost_now", signal_lost, 0);
    drive(1'b0, 10);
    drive(1'b1, 10);
    check_eq("after_rearm_pv", last_pv, 1);
    check_eq("after_rearm_period", last_period, 20);

    // Reset in the middle of a fall filter count and a period count.
    drive(1'b0, 3);
    rst    = 1'b1;
    pin_in = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq($sformatf("rel_rise_%0d", k), rise_pulse, (k == 6));
      check_eq($sformatf("rel_fall_%0d", k), fall_pulse, 0);
      if (k == 1) begin
        check_eq("rel_level", level, 0);
        check_eq("rel_period", period, 0);
        check_eq("rel_pv", period_valid, 0);
        check_eq("rel_edge_count", edge_count, 0);
        check_eq("rel_lost", signal_lost, 1);
      end
      if (k == 6) begin
        check_eq("rel_edge_count_rise", edge_count, 1);
        check_eq("rel_pv_rise", period_valid, 0);
      end
    end

    // 65537 rises on the unfiltered instance wraps edge_count to 1.
    check_eq("wrap_start", edge_count2, 0);
    for (int i = 0; i < 2 * 65535; i++) begin
      pin2 = ~pin2;
      tick();
    end
    repeat (4) tick();
    check_eq("wrap_ffff", edge_count2, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      pin2 = ~pin2;
      tick();
    end
    repeat (4) tick();
    check_eq("wrap_one", edge_count2, 1);

    check_eq("never_both", both_cnt, 0);
    check_eq("pv_only_with_rise", pv_orphan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
